// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch reads it combinationally; execute trains it on every resolved branch
// or jump. It also keeps saturating hit and mispredict event counters.

// One BTB entry: valid, tag, target and 2-bit direction counter.
module bp_entry #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  hit_upd_i,
    input  logic                  alloc_i,
    input  logic                  upd_taken_i,
    input  logic [TAG_W-1:0]      upd_tag_i,
    input  logic [DATA_WIDTH-1:0] upd_target_i,
    output logic                  valid_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [DATA_WIDTH-1:0] target_o,
    output logic [1:0]            ctr_o
);

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic                  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [1:0]            ctr_q, ctr_d;

    // Next entry state: flush beats allocation beats a training update.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (alloc_i) begin
            valid_d  = 1'b1;
            tag_d    = upd_tag_i;
            target_d = upd_target_i;
            ctr_d    = CTR_WT;
        end else if (hit_upd_i) begin
            if (upd_taken_i) begin
                target_d = upd_target_i;
                if (ctr_q != CTR_ST) ctr_d = ctr_q + 2'd1;
            end else begin
                if (ctr_q != CTR_SNT) ctr_d = ctr_q - 2'd1;
            end
        end
    end

    // Entry storage; reset leaves entries invalid and weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= CTR_WNT;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    assign valid_o  = valid_q;
    assign tag_o    = tag_q;
    assign target_o = target_q;
    assign ctr_o    = ctr_q;

endmodule

// BTB top: lookup mux, update steering and event counters.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic [DATA_WIDTH-1:0] predict_target,
    input  logic                  update_en,
    input  logic [DATA_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [DATA_WIDTH-1:0] update_target,
    input  logic                  update_mispredict,
    input  logic                  flush,
    output logic [31:0]           hit_count,
    output logic [31:0]           mispredict_count
);

    localparam int TAG_W = DATA_WIDTH - INDEX_BITS - 2;

    logic [INDEX_BITS-1:0] f_idx, u_idx;
    logic [TAG_W-1:0]      f_tag, u_tag;

    logic [ENTRIES-1:0]                 ent_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]      ent_tag;
    logic [ENTRIES-1:0][DATA_WIDTH-1:0] ent_target;
    logic [ENTRIES-1:0][1:0]            ent_ctr;

    logic u_hit;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] mp_cnt_q, mp_cnt_d;

    // Word-aligned PCs: low two bits never take part in index or tag.
    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign f_tag = fetch_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign u_idx = update_pc[INDEX_BITS+1:2];
    assign u_tag = update_pc[DATA_WIDTH-1:INDEX_BITS+2];

    assign u_hit = ent_valid[u_idx] && (ent_tag[u_idx] == u_tag);

    // Only the indexed entry sees an update; flush drops it entirely.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        localparam logic [INDEX_BITS-1:0] IDX = INDEX_BITS'(g);
        logic sel;
        assign sel = update_en && !flush && (u_idx == IDX);

        bp_entry #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_W      (TAG_W)
        ) u_ent (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (flush),
            .hit_upd_i    (sel && u_hit),
            .alloc_i      (sel && !u_hit && update_taken),
            .upd_taken_i  (update_taken),
            .upd_tag_i    (u_tag),
            .upd_target_i (update_target),
            .valid_o      (ent_valid[g]),
            .tag_o        (ent_tag[g]),
            .target_o     (ent_target[g]),
            .ctr_o        (ent_ctr[g])
        );
    end

    // Zero-latency lookup; target is forced to zero on a miss.
    always_comb begin
        predict_valid  = ent_valid[f_idx] && (ent_tag[f_idx] == f_tag);
        predict_taken  = predict_valid && ent_ctr[f_idx][1];
        predict_target = predict_valid ? ent_target[f_idx] : '0;
    end

    // Saturating event counters; mispredict is only meaningful with update_en.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        mp_cnt_d  = mp_cnt_q;
        if (predict_valid && (hit_cnt_q != 32'hFFFF_FFFF))
            hit_cnt_d = hit_cnt_q + 32'd1;
        if (update_en && update_mispredict && (mp_cnt_q != 32'hFFFF_FFFF))
            mp_cnt_d = mp_cnt_q + 32'd1;
    end

    // Counter registers; cleared only by reset, never by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q <= '0;
            mp_cnt_q  <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            mp_cnt_q  <= mp_cnt_d;
        end
    end

    assign hit_count        = hit_cnt_q;
    assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_branch_predictor;

    localparam logic [31:0] IDLE = 32'h0000_0F00; // index 0, tag never allocated

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        predict_valid, predict_taken;
    logic [31:0] predict_target;
    logic        update_en, update_taken, update_mispredict, flush;
    logic [31:0] update_pc, update_target;
    logic [31:0] hit_count, mispredict_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_pc          (fetch_pc),
        .predict_valid     (predict_valid),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .update_en         (update_en),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .flush             (flush),
        .hit_count         (hit_count),
        .mispredict_count  (mispredict_count)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One resolved instruction across one rising edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
        update_en = 1'b1; update_pc = pc; update_taken = tk;
        update_target = tgt; update_mispredict = mp;
        step();
        update_en = 1'b0; update_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; fetch_pc = 32'h100; update_en = 0; update_pc = 0;
        update_taken = 0; update_target = 0; update_mispredict = 0; flush = 0;
        #2;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %h want 0", predict_valid); end
        n_vec++; if (predict_taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %h want 0", predict_taken); end
        n_vec++; if (predict_target !== 32'h0) begin n_bad++; $display("FAIL reset_target: got %h want 0", predict_target); end
        n_vec++; if (hit_count !== 32'h0) begin n_bad++; $display("FAIL reset_hits: got %h want 0", hit_count); end
        n_vec++; if (mispredict_count !== 32'h0) begin n_bad++; $display("FAIL reset_mp: got %h want 0", mispredict_count); end
        @(negedge clk);
        rst = 1'b1; fetch_pc = IDLE;
        step();
    endtask

    task automatic test_alloc();
        upd(32'h100, 1'b1, 32'h200, 1'b1);
        #1;
        n_vec++; if (mispredict_count !== 32'd1) begin n_bad++; $display("FAIL alloc_mp: got %h want 1", mispredict_count); end
        update_mispredict = 1'b1;     // without update_en: must be ignored
        step();
        update_mispredict = 1'b0;
        #1;
        n_vec++; if (mispredict_count !== 32'd1) begin n_bad++; $display("FAIL mp_no_en: got %h want 1", mispredict_count); end
        fetch_pc = 32'h100;
        #1;
        n_vec++; if (predict_valid !== 1'b1) begin n_bad++; $display("FAIL alloc_valid: got %h want 1", predict_valid); end
        n_vec++; if (predict_taken !== 1'b1) begin n_bad++; $display("FAIL alloc_taken: got %h want 1", predict_taken); end
        n_vec++; if (predict_target !== 32'h200) begin n_bad++; $display("FAIL alloc_target: got %h want 200", predict_target); end
        n_vec++; if (hit_count !== 32'd0) begin n_bad++; $display("FAIL hits_0: got %h want 0", hit_count); end
        step(); #1;
        n_vec++; if (hit_count !== 32'd1) begin n_bad++; $display("FAIL hits_1: got %h want 1", hit_count); end
        step(); #1;
        n_vec++; if (hit_count !== 32'd2) begin n_bad++; $display("FAIL hits_2: got %h want 2", hit_count); end
        fetch_pc = IDLE;
    endtask

    task automatic test_counter();
        // counter path from WT: 01,00,00(sat),01,10,11,11(sat),10,01
        bit tk_seq[9]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        bit exp_tk[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            // not-taken updates carry a bogus target that must not be written
            upd(32'h100, tk_seq[i], tk_seq[i] ? 32'h200 : 32'h999, 1'b0);
            fetch_pc = 32'h100;
            #1;
            n_vec++; if (predict_valid !== 1'b1) begin n_bad++; $display("FAIL ctr_valid[%0d]: got %h want 1", i, predict_valid); end
            n_vec++; if (predict_taken !== exp_tk[i]) begin n_bad++; $display("FAIL ctr_taken[%0d]: got %h want %h", i, predict_taken, exp_tk[i]); end
            n_vec++; if (predict_target !== 32'h200) begin n_bad++; $display("FAIL ctr_target[%0d]: got %h want 200", i, predict_target); end
            fetch_pc = IDLE;
        end
        // miss + not-taken leaves the table alone
        upd(32'h180, 1'b0, 32'h600, 1'b0);
        fetch_pc = 32'h180; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL nt_miss_alloc: got %h want 0", predict_valid); end
        fetch_pc = 32'h100; #1;
        n_vec++; if (predict_valid !== 1'b1) begin n_bad++; $display("FAIL nt_miss_keep: got %h want 1", predict_valid); end
        fetch_pc = IDLE;
        n_vec++; if (hit_count !== 32'd2) begin n_bad++; $display("FAIL ctr_hits: got %h want 2", hit_count); end
    endtask

    task automatic test_alias();
        fetch_pc = 32'h140; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL alias_valid: got %h want 0", predict_valid); end
        n_vec++; if (predict_target !== 32'h0) begin n_bad++; $display("FAIL alias_target: got %h want 0", predict_target); end
        fetch_pc = IDLE;
        upd(32'h140, 1'b1, 32'h300, 1'b0);
        fetch_pc = 32'h140; #1;
        n_vec++; if (predict_valid !== 1'b1) begin n_bad++; $display("FAIL repl_valid: got %h want 1", predict_valid); end
        n_vec++; if (predict_taken !== 1'b1) begin n_bad++; $display("FAIL repl_taken: got %h want 1", predict_taken); end
        n_vec++; if (predict_target !== 32'h300) begin n_bad++; $display("FAIL repl_target: got %h want 300", predict_target); end
        fetch_pc = 32'h100; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL evicted_valid: got %h want 0", predict_valid); end
        n_vec++; if (predict_taken !== 1'b0) begin n_bad++; $display("FAIL evicted_taken: got %h want 0", predict_taken); end
        fetch_pc = IDLE;
    endtask

    task automatic test_back_to_back();
        upd(32'h100, 1'b1, 32'h200, 1'b0);    // re-allocate over 0x140
        update_en = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h400;
        fetch_pc = 32'h100; #1;
        n_vec++; if (predict_valid !== 1'b1) begin n_bad++; $display("FAIL same_valid: got %h want 1", predict_valid); end
        n_vec++; if (predict_target !== 32'h200) begin n_bad++; $display("FAIL same_old_target: got %h want 200", predict_target); end
        step();
        update_en = 1'b0; #1;
        n_vec++; if (predict_target !== 32'h400) begin n_bad++; $display("FAIL same_new_target: got %h want 400", predict_target); end
        n_vec++; if (hit_count !== 32'd3) begin n_bad++; $display("FAIL same_hits: got %h want 3", hit_count); end
        fetch_pc = IDLE;
        upd(32'h104, 1'b1, 32'h500, 1'b0);    // second live entry, index 1
        flush = 1'b1;
        upd(32'h180, 1'b1, 32'h600, 1'b0);    // dropped by flush
        flush = 1'b0;
        fetch_pc = 32'h100; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL flush_100: got %h want 0", predict_valid); end
        fetch_pc = 32'h104; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL flush_104: got %h want 0", predict_valid); end
        fetch_pc = 32'h180; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL flush_upd_dropped: got %h want 0", predict_valid); end
        fetch_pc = IDLE;
        n_vec++; if (hit_count !== 32'd3) begin n_bad++; $display("FAIL flush_hits: got %h want 3", hit_count); end
    endtask

    task automatic test_async_reset();
        upd(32'h104, 1'b1, 32'h500, 1'b0);
        update_en = 1'b1; update_pc = 32'h108; update_taken = 1'b1;
        update_target = 32'h700; update_mispredict = 1'b1;
        fetch_pc = 32'h104; #1;
        n_vec++; if (predict_target !== 32'h500) begin n_bad++; $display("FAIL pre_rst_target: got %h want 500", predict_target); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %h want 0", predict_valid); end
        n_vec++; if (predict_taken !== 1'b0) begin n_bad++; $display("FAIL arst_taken: got %h want 0", predict_taken); end
        n_vec++; if (predict_target !== 32'h0) begin n_bad++; $display("FAIL arst_target: got %h want 0", predict_target); end
        n_vec++; if (hit_count !== 32'h0) begin n_bad++; $display("FAIL arst_hits: got %h want 0", hit_count); end
        n_vec++; if (mispredict_count !== 32'h0) begin n_bad++; $display("FAIL arst_mp: got %h want 0", mispredict_count); end
        @(negedge clk);
        update_en = 1'b0; update_mispredict = 1'b0;
        rst = 1'b1; fetch_pc = IDLE;
        step();
        fetch_pc = 32'h108; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL arst_no_alloc: got %h want 0", predict_valid); end
        fetch_pc = 32'h104; #1;
        n_vec++; if (predict_valid !== 1'b0) begin n_bad++; $display("FAIL arst_cleared: got %h want 0", predict_valid); end
        fetch_pc = IDLE;
    endtask

    task automatic test_saturation();
        force dut.mp_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.mp_cnt_q;
        upd(32'h10C, 1'b0, 32'h0, 1'b1);
        #1;
        n_vec++; if (mispredict_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mp_sat: got %h want ffffffff", mispredict_count); end
        upd(32'h104, 1'b1, 32'h500, 1'b0);
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.hit_cnt_q;
        fetch_pc = 32'h104;
        step(); #1;
        n_vec++; if (hit_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL hit_to_max: got %h want ffffffff", hit_count); end
        step(); #1;
        n_vec++; if (hit_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL hit_sat: got %h want ffffffff", hit_count); end
        fetch_pc = IDLE;
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It supplies predict_valid, predict_taken and predict_target to the fetch stage for the current fetch PC. It is trained by branch/jump resolution updates from the execute stage, which is the same stage that drives PCSrc and Hazard_target into fetch. It also keeps hit and mispredict performance counters.

Parameters:
DATA_WIDTH, 32, PC/target width.
ENTRIES, 16, number of BTB entries; power of two, minimum 2.
INDEX_BITS, $clog2(ENTRIES), derived; not overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
fetch_pc  input  DATA_WIDTH  PC currently being fetched.
predict_valid  output  1  BTB hit for fetch_pc.
predict_taken  output  1  direction prediction for fetch_pc.
predict_target  output  DATA_WIDTH  predicted target for fetch_pc.
update_en  input  1  resolved control-flow instruction this cycle.
update_pc  input  DATA_WIDTH  PC of the resolved instruction.
update_taken  input  1  actual outcome.
update_target  input  DATA_WIDTH  actual target.
update_mispredict  input  1  execute stage redirected fetch (PCSrc) for this instruction.
flush  input  1  synchronously invalidate all entries.
hit_count  output  32  lookups with predict_valid=1.
mispredict_count  output  32  updates with update_mispredict=1.

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[DATA_WIDTH-1:INDEX_BITS+2]; pc[1:0] ignored.
- Each entry holds a valid bit, a tag, a target and a 2-bit counter: 00 strongly not-taken (SNT), 01 weakly not-taken (WNT), 10 weakly taken (WT), 11 strongly taken (ST).
- Lookup is purely combinational, with zero latency:
  - predict_valid = valid[idx] and (tag[idx] == fetch_tag).
  - predict_taken = predict_valid and counter[idx][1].
  - predict_target = target[idx] when predict_valid, else 0.
- Updates are applied on the rising edge when update_en=1.
  - Hit (valid and tag match): counter increments on taken and decrements on not-taken, saturating at 11 and 00. target is overwritten only when update_taken=1.
  - Miss and update_taken=1: allocate the entry, overwriting any aliasing entry. Set valid=1, tag, target=update_target, counter=10 (WT).
  - Miss and update_taken=0: no change to the table.
- No read bypass. A lookup and an update to the same index in the same cycle return the pre-update contents; the new contents are visible the next cycle.
- flush: on the next edge all valid bits clear. Tags, targets and counters are don't-care. If flush and update_en are both 1 in the same cycle, flush wins and the update is dropped.
- hit_count increments each cycle predict_valid=1.
- mispredict_count increments each edge with update_en=1 and update_mispredict=1. update_mispredict is ignored when update_en=0.
- Both performance counters saturate at 32'hFFFF_FFFF. Neither is cleared by flush.
- Reset (rst=0, asynchronous, takes effect immediately, including mid-update):
  - all valid bits=0, all counters=01, hit_count=0, mispredict_count=0.
  - Resulting outputs: predict_valid=0, predict_taken=0, predict_target=0.
  - Table state is held in reset while rst=0; normal operation resumes on the first edge after rst deasserts.
- No stall input. The caller asserts update_en exactly once per resolved instruction.

Test Plan:
1. Reset, then fetch_pc=0x100 -> predict_valid=0, predict_taken=0, predict_target=0, hit_count=0.
2. Update pc=0x100, taken=1, target=0x200 -> next cycle fetch_pc=0x100 gives valid=1, taken=1, target=0x200, and hit_count increments each such cycle.
3. From state 2, apply two not-taken updates to 0x100 -> counter=00, predict_valid=1, predict_taken=0, target still 0x200. Then three taken updates -> counter=11. Then one not-taken update -> counter=10, still predicted taken.
4. Aliasing with ENTRIES=16: 0x100 is allocated and fetch_pc=0x140 (same index 0, different tag) -> predict_valid=0. A taken update of 0x140 with target=0x300 replaces the entry, and lookup of 0x100 then misses.
5. Same-cycle update of 0x100 (taken, target 0x400) while fetch_pc=0x100 on an entry holding target=0x200 -> that cycle shows target=0x200, next cycle shows 0x400. Flush asserted together with an update -> the following cycle all lookups miss and the update is not applied.
6. Assert rst low asynchronously between clock edges while update_en=1 -> outputs go to 0 immediately, both counters read 0, and no entry is allocated after rst deasserts. Separately, preload mispredict_count=32'hFFFF_FFFF via forced state, then apply a mispredicting update -> count stays 32'hFFFF_FFFF.
